secded_dec_engine: RTL

Hardware SECDED Hamming decoder engine, the receive-side counterpart of the program-1 parity encoder.
- On a start pulse it walks NUM_MSG 16-bit codewords stored as byte pairs in data memory.
- For each codeword it computes the syndrome and overall parity, corrects single-bit errors and flags double-bit errors.
- It writes the 11-bit message plus a 2-bit status back to memory as byte pairs.
- It sits beside the core as a memory-mapped accelerator sharing the byte-wide data-memory port.

---
 rtl/secded_dec_engine.sv | 121 ++++++++++++
 1 files changed

// File: rtl/secded_dec_engine.sv
// SECDED Hamming decoder engine: reads NUM_MSG 16-bit codewords from byte memory,
// corrects single-bit errors, flags double-bit errors and writes message+status back.
module secded_dec_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    output logic [3:0]    single_cnt,
    output logic [3:0]    double_cnt
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic [15:0]     cw;
    logic [7:0]      res_lo, res_hi;
    logic [3:0]      syn;
    logic            par;
    logic [15:0]     fix;
    logic [1:0]      st;
    logic [AW-1:0]   src_addr, dst_addr;
    logic            last;

    always_comb begin
        src_addr = AW'(SRC_BASE) + (AW'(idx) << 1);
        dst_addr = AW'(DST_BASE) + (AW'(idx) << 1);
        last     = (idx == IW'(NUM_MSG - 1));
    end

    // Syndrome is the XOR of the positions of all set bits; bit 0 only feeds global parity.
    always_comb begin
        syn = '0;
        for (int unsigned k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        par = ^cw;
        fix = cw;
        if (par && syn != 4'd0) fix[syn] = ~fix[syn];
        if (par)               st = 2'b01;
        else if (syn != 4'd0)  st = 2'b10;
        else                   st = 2'b00;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RD_LO;
            RD_LO:      state_nx = RD_HI;
            RD_HI:      state_nx = CAP;
            CAP:        state_nx = DEC;
            DEC:        state_nx = WR_LO;
            WR_LO:      state_nx = WR_HI;
            WR_HI:      state_nx = last ? DONE : RD_LO;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        done      = (state == DONE);
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            RD_LO: begin mem_rd_en = 1'b1; mem_addr = src_addr; end
            RD_HI: begin mem_rd_en = 1'b1; mem_addr = src_addr + AW'(1); end
            WR_LO: begin mem_wr_en = 1'b1; mem_addr = dst_addr; mem_wdata = res_lo; end
            WR_HI: begin mem_wr_en = 1'b1; mem_addr = dst_addr + AW'(1); mem_wdata = res_hi; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cw         <= '0;
            res_lo     <= '0;
            res_hi     <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= '0;
                        single_cnt <= '0;
                        double_cnt <= '0;
                    end
                end
                RD_HI: cw[7:0]  <= mem_rdata;
                CAP:   cw[15:8] <= mem_rdata;
                DEC: begin
                    res_lo <= {fix[12], fix[11], fix[10], fix[9], fix[7], fix[6], fix[5], fix[3]};
                    res_hi <= {st, 3'b000, fix[15], fix[14], fix[13]};
                    if (st == 2'b01) single_cnt <= single_cnt + 4'd1;
                    if (st == 2'b10) double_cnt <= double_cnt + 4'd1;
                end
                WR_HI: if (!last) idx <= idx + IW'(1);
                default: ;
            endcase
        end
    end

endmodule
